// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data_mem bus bundle for lsu_mem_ctrl.
// slave is the controller's view; master is the core/memory-model side.
interface lsu_mem_ctrl_if #(
  parameter int unsigned ADR_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [31:0]      req_addr;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_wdata;
  logic             resp_valid;
  logic [31:0]      resp_rdata;
  logic             resp_err;
  logic [ADR_W-1:0] mem_adr;
  logic             mem_we;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_adr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_adr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store initiator for data_mem: extension on loads, RMW merge on sub-word stores.
// Optional LSU_STATS_EN adds saturating load/store/error response counters.
module lsu_mem_ctrl #(
  parameter int unsigned ADR_W  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  lsu_mem_ctrl_if.slave        bus
`ifdef LSU_STATS_EN
  ,
  output logic [15:0]          stat_loads,
  output logic [15:0]          stat_stores,
  output logic [15:0]          stat_errs
`endif
);

  localparam int unsigned HI_SHIFT = ADR_W + 2;

  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic        err_c;

  // Select the addressed lane of a read word and extend it to full width.
  function automatic word_t load_ext(input word_t w, input logic [1:0] size,
                                     input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  // Replace only the addressed byte/half of the old word.
  function automatic word_t st_merge(input word_t old, input logic [15:0] wd,
                                     input logic [1:0] size, input logic [1:0] off);
    word_t mask;
    word_t data;
    if (size == 2'b00) begin
      mask = 32'h0000_00FF << {off, 3'b000};
      data = {24'd0, wd[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {off[1], 4'b0000};
      data = {16'd0, wd} << {off[1], 4'b0000};
    end
    st_merge = (old & ~mask) | (data & mask);
  endfunction

  always_comb begin
    err_c = 1'b0;
    if (bus.req_size == 2'b11)                              err_c = 1'b1;
    if (bus.req_size == 2'b01 && bus.req_addr[0])           err_c = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) err_c = 1'b1;
    if ((bus.req_addr >> HI_SHIFT) != 32'd0)                err_c = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_adr     <= '0;
      bus.mem_wdata   <= '0;
      we_q            <= 1'b0;
      uns_q           <= 1'b0;
      size_q          <= 2'b00;
      off_q           <= 2'b00;
      wdata_q         <= 16'd0;
`ifdef LSU_STATS_EN
      stat_loads      <= 16'd0;
      stat_stores     <= 16'd0;
      stat_errs       <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            we_q          <= bus.req_we;
            uns_q         <= bus.req_unsigned;
            size_q        <= bus.req_size;
            off_q         <= bus.req_addr[1:0];
            wdata_q       <= bus.req_wdata[15:0];
            bus.req_ready <= 1'b0;
            if (err_c) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (bus.req_we && bus.req_size == 2'b10) begin
              state         <= WRITE;
              bus.mem_adr   <= bus.req_addr[ADR_W+1:2];
              bus.mem_we    <= 1'b1;
              bus.mem_wdata <= bus.req_wdata;
            end else begin
              // Loads and sub-word stores both fetch the addressed word first.
              state       <= READ;
              bus.mem_adr <= bus.req_addr[ADR_W+1:2];
            end
          end
        end
        READ: begin
          if (!we_q) begin
            state          <= RESP;
            bus.mem_adr    <= '0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= load_ext(bus.mem_rdata, size_q, off_q, uns_q);
          end else begin
            state         <= WRITE;
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= st_merge(bus.mem_rdata, wdata_q, size_q, off_q);
          end
        end
        WRITE: begin
          state          <= RESP;
          bus.mem_we     <= 1'b0;
          bus.mem_wdata  <= '0;
          bus.mem_adr    <= '0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        default: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
`ifdef LSU_STATS_EN
          if (bus.resp_err) begin
            if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
          end else if (we_q) begin
            if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
          end else begin
            if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed vector bench for lsu_mem_ctrl with a behavioural data_mem model.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.ADR_W(8)) bus ();

`ifdef LSU_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  lsu_mem_ctrl #(.ADR_W(8), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef LSU_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  // data_mem model: combinational read, write on rising edge
  logic [31:0] mem [256];
  int          we_cnt = 0;
  logic [7:0]  last_wadr = 8'd0;
  logic [31:0] last_wdata = 32'd0;
  assign bus.mem_rdata = mem[bus.mem_adr];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_adr] <= bus.mem_wdata;
      we_cnt     <= we_cnt + 1;
      last_wadr  <= bus.mem_adr;
      last_wdata <= bus.mem_wdata;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  // Issue one request, measure response latency and write pulses, compare to v.
  task automatic run(input vec_t v, input string tag);
    int lat;
    int w0;
    int guard;
    logic [7:0] wadr;
    logic [31:0] a;
    a = v.addr;
    wadr = a[9:2];
    guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready_wait"}, 32'(guard < 20), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_addr     = v.addr;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_wdata    = v.wdata;
    w0 = we_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = 32'hDEAD_DEAD;
    chk({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_rdata"}, bus.resp_rdata, v.exp_rdata);
    chk({tag, "_err"}, 32'(bus.resp_err), 32'(v.exp_err));
    chk({tag, "_wepulses"}, 32'(we_cnt - w0), 32'(v.exp_we));
    if (v.exp_we != 0) begin
      chk({tag, "_wadr"}, 32'(last_wadr), 32'(wadr));
      chk({tag, "_wdata"}, last_wdata, v.exp_wdata);
    end
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    int w0;
    int seen;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'd0;
    bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.req_wdata = 32'd0;

    //            we  addr          sz uns wdata          rdata          err lat we wdata
    vecs[0]  = '{1'b1, 32'h004, 2'd2, 1'b0, 32'd22,        32'd0,         1'b0, 2, 1, 32'd22};
    vecs[1]  = '{1'b0, 32'h004, 2'd2, 1'b0, 32'd0,         32'd22,        1'b0, 2, 0, 32'd0};
    vecs[2]  = '{1'b1, 32'h008, 2'd2, 1'b0, 32'h11223344, 32'd0,         1'b0, 2, 1, 32'h11223344};
    vecs[3]  = '{1'b1, 32'h00A, 2'd0, 1'b0, 32'h123456AB, 32'd0,         1'b0, 3, 1, 32'h11AB3344};
    vecs[4]  = '{1'b0, 32'h008, 2'd2, 1'b0, 32'd0,         32'h11AB3344, 1'b0, 2, 0, 32'd0};
    vecs[5]  = '{1'b0, 32'h00A, 2'd0, 1'b0, 32'd0,         32'hFFFFFFAB, 1'b0, 2, 0, 32'd0};
    vecs[6]  = '{1'b0, 32'h00A, 2'd0, 1'b1, 32'd0,         32'h000000AB, 1'b0, 2, 0, 32'd0};
    vecs[7]  = '{1'b1, 32'h008, 2'd2, 1'b0, 32'h80017FFF, 32'd0,         1'b0, 2, 1, 32'h80017FFF};
    vecs[8]  = '{1'b0, 32'h00A, 2'd1, 1'b0, 32'd0,         32'hFFFF8001, 1'b0, 2, 0, 32'd0};
    vecs[9]  = '{1'b0, 32'h008, 2'd1, 1'b0, 32'd0,         32'h00007FFF, 1'b0, 2, 0, 32'd0};
    vecs[10] = '{1'b0, 32'h00A, 2'd1, 1'b1, 32'd0,         32'h00008001, 1'b0, 2, 0, 32'd0};
    vecs[11] = '{1'b0, 32'h008, 2'd2, 1'b1, 32'd0,         32'h80017FFF, 1'b0, 2, 0, 32'd0};
    vecs[12] = '{1'b1, 32'h00C, 2'd2, 1'b0, 32'hCAFEF00D, 32'd0,         1'b0, 2, 1, 32'hCAFEF00D};
    vecs[13] = '{1'b1, 32'h00E, 2'd1, 1'b0, 32'h1234BEEF, 32'd0,         1'b0, 3, 1, 32'hBEEFF00D};
    vecs[14] = '{1'b1, 32'h00D, 2'd0, 1'b0, 32'h00000055, 32'd0,         1'b0, 3, 1, 32'hBEEF550D};
    vecs[15] = '{1'b0, 32'h00F, 2'd0, 1'b0, 32'd0,         32'hFFFFFFBE, 1'b0, 2, 0, 32'd0};
    vecs[16] = '{1'b0, 32'h00C, 2'd2, 1'b0, 32'd0,         32'hBEEF550D, 1'b0, 2, 0, 32'd0};
    vecs[17] = '{1'b0, 32'h00B, 2'd0, 1'b1, 32'd0,         32'h00000080, 1'b0, 2, 0, 32'd0};
    vecs[18] = '{1'b1, 32'h3FC, 2'd2, 1'b0, 32'hA5A5A5A5, 32'd0,         1'b0, 2, 1, 32'hA5A5A5A5};
    vecs[19] = '{1'b0, 32'h3FE, 2'd1, 1'b0, 32'd0,         32'hFFFFA5A5, 1'b0, 2, 0, 32'd0};
    vecs[20] = '{1'b0, 32'h006, 2'd2, 1'b0, 32'd0,         32'd0,         1'b1, 1, 0, 32'd0};
    vecs[21] = '{1'b0, 32'h003, 2'd1, 1'b0, 32'd0,         32'd0,         1'b1, 1, 0, 32'd0};
    vecs[22] = '{1'b0, 32'h000, 2'd3, 1'b0, 32'd0,         32'd0,         1'b1, 1, 0, 32'd0};
    vecs[23] = '{1'b0, 32'h400, 2'd2, 1'b0, 32'd0,         32'd0,         1'b1, 1, 0, 32'd0};
    vecs[24] = '{1'b1, 32'h400, 2'd2, 1'b0, 32'hDEADBEEF, 32'd0,         1'b1, 1, 0, 32'd0};
    vecs[25] = '{1'b1, 32'h001, 2'd1, 1'b0, 32'h0000FFFF, 32'd0,         1'b1, 1, 0, 32'd0};
    vecs[26] = '{1'b1, 32'h3FF, 2'd0, 1'b0, 32'h00000011, 32'd0,         1'b0, 3, 1, 32'h11A5A5A5};
    vecs[27] = '{1'b0, 32'h3FC, 2'd2, 1'b0, 32'd0,         32'h11A5A5A5, 1'b0, 2, 0, 32'd0};
    vecs[28] = '{1'b0, 32'h10000000, 2'd0, 1'b0, 32'd0,    32'd0,         1'b1, 1, 0, 32'd0};

    // Reset for two cycles, then release
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_adr", 32'(bus.mem_adr), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);

    for (int i = 0; i < NV; i++) run(vecs[i], $sformatf("v%0d", i));

    // Sub-word store abandoned by reset during its READ cycle
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h008;
    bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.req_wdata = 32'h77;
    w0 = we_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("abort_in_read_adr", 32'(bus.mem_adr), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort_mem_adr", 32'(bus.mem_adr), 32'd0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid || bus.mem_we) seen++;
    end
    chk("abort_no_activity", 32'(seen), 32'd0);
    chk("abort_no_write", 32'(we_cnt - w0), 32'd0);
    chk("abort_mem_word", mem[2], 32'h80017FFF);
`ifdef LSU_STATS_EN
    chk("stat_loads_clr", 32'(stat_loads), 32'd0);
    chk("stat_stores_clr", 32'(stat_stores), 32'd0);
    chk("stat_errs_clr", 32'(stat_errs), 32'd0);
`endif
    v = '{1'b0, 32'h008, 2'd2, 1'b0, 32'd0, 32'h80017FFF, 1'b0, 2, 0, 32'd0};
    run(v, "post_abort_load");

    // Response data and error flag hold after the pulse
    repeat (3) @(posedge clk);
    #1;
    chk("hold_rdata", bus.resp_rdata, 32'h80017FFF);
    chk("hold_err", 32'(bus.resp_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives the data_mem port (word address, write enable, write data, read data) on behalf of the core.
- Accepts byte-addressed load/store requests of byte, half and word size. Performs sign/zero extension on loads and read-modify-write merging on sub-word stores.
- Flags misaligned and out-of-range accesses without touching memory.
- Sits between the execute stage and data_mem; a multi-cycle front end for the data path.

Parameters:
- ADR_W, 8, width of data_mem word address; addressable range is 2^ADR_W words.
- DATA_W, 32, data word width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, out-of-range or illegal size
- mem_adr  out  ADR_W  word address to data_mem (req_addr[ADR_W+1:2])
- mem_we  out  1  data_mem write enable
- mem_wdata  out  32  data_mem write data
- mem_rdata  in  32  data_mem read data; combinational from mem_adr

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset (synchronous, highest priority):
  - state=IDLE.
  - req_ready=1 from the first cycle after reset.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_adr=0, mem_wdata=0.
  - Reset asserted mid-operation abandons the request: no response, and mem_we is 0 in the next cycle. A write already sampled by data_mem on the reset edge is not undone.
- req_ready=1 only in IDLE. Handshake: req_valid&req_ready at a rising edge captures req_* into internal registers. Inputs are ignored outside IDLE.
- Error check at capture. err if any of:
  - req_size==11
  - half with addr[0]!=0
  - word with addr[1:0]!=0
  - addr[31:ADR_W+2]!=0
- Error path: IDLE -> RESP; resp_err=1, resp_rdata=0, no memory cycle.
- Load: IDLE -> READ -> RESP.
  - In READ, mem_adr = captured word address and mem_rdata is registered.
  - Lane selected by addr[1:0] (byte) or addr[1] (half), then extended per req_unsigned. Word loads ignore req_unsigned.
  - Latency: resp_valid asserted 2 cycles after the accepting edge.
- Store word: IDLE -> WRITE -> RESP.
  - mem_we=1 for exactly one cycle in WRITE, with mem_wdata=req_wdata.
- Store byte/half: IDLE -> READ -> WRITE -> RESP.
  - READ registers the old word.
  - WRITE drives the merged word: only the selected lane is replaced by the low bits of req_wdata, all other bits come from the old word.
  - Response latency is 3 cycles.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Next request acceptance:
  - req_ready returns in the cycle after RESP, so back-to-back requests are spaced by at least one idle cycle.
  - A store followed by a load to the same address returns the stored data.
- mem_adr holds the captured address in READ and WRITE, and 0 otherwise. mem_we=1 only in WRITE. mem_wdata=0 outside WRITE.
- resp_rdata and resp_err hold their values until the next RESP or reset.

Optional Feature:
- Macro: LSU_STATS_EN.
- Defined:
  - Adds outputs stat_loads[15:0], stat_stores[15:0] and stat_errs[15:0].
  - Each counter increments once per completed response of its kind (in RESP) and saturates at 16'hFFFF.
  - All counters clear on rst.
  - stat_loads and stat_stores count only non-error responses.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset for 2 cycles, then release -> req_ready=1, mem_we=0, resp_valid=0, mem_adr=0.
- Store word 32'd22 to addr 0x04, then load word from 0x04 -> mem_we pulses once with mem_adr=1 and mem_wdata=22; load resp_rdata=32'd22 with resp_valid 2 cycles after accept.
- Preload word 0x11223344 at addr 0x08, then store byte 0xAB to 0x0A -> memory word is 0x11AB3344. Load byte signed from 0x0A -> 0xFFFFFFAB; load byte unsigned -> 0x000000AB.
- Load half signed from 0x08 containing 0x8001_7FFF: offset 2 -> 0xFFFF8001, offset 0 -> 0x00007FFF.
- Word load at 0x06, half at 0x03, size 11, and addr 0x400 (ADR_W=8) -> each gives resp_err=1, resp_rdata=0, mem_we never asserted, response 1 cycle after accept.
- Sub-word store, with rst asserted during the READ cycle -> next cycle state IDLE, mem_we=0, no resp_valid, memory word unchanged. With LSU_STATS_EN, all counters read 0.
